sdram_arbit: RTL

SDRAM_ARBIT -- requirements
Module: sdram_arbit

---
 rtl/sdram_arbit.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/sdram_arbit.sv
// rtl/sdram_arbit.sv - SDRAM command bus arbiter for init/refresh/write/read sub-modules.
// Optional macro SDRAM_ARB_RR_EN: write/read round-robin when both request together.
module sdram_arbit #(
  parameter logic [3:0] CMD_NOP = 4'b0111,
  parameter int         ADDR_W  = 13
) (
  input  logic              sys_clk,
  input  logic              sys_rst,
  input  logic              init_end,
  input  logic [3:0]        init_cmd,
  input  logic [1:0]        init_ba,
  input  logic [ADDR_W-1:0] init_addr,
  input  logic              aref_req,
  input  logic              aref_end,
  input  logic [3:0]        aref_cmd,
  input  logic [1:0]        aref_ba,
  input  logic [ADDR_W-1:0] aref_addr,
  input  logic              wr_req,
  input  logic              wr_end,
  input  logic              wr_dq_oe,
  input  logic [3:0]        wr_cmd,
  input  logic [1:0]        wr_ba,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [15:0]       wr_data,
  input  logic              rd_req,
  input  logic              rd_end,
  input  logic [3:0]        rd_cmd,
  input  logic [1:0]        rd_ba,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic              aref_en,
  output logic              wr_en,
  output logic              rd_en,
  output logic [3:0]        sdram_cmd,
  output logic [1:0]        sdram_ba,
  output logic [ADDR_W-1:0] sdram_addr,
  output logic              sdram_dq_oe,
  output logic [15:0]       sdram_dq_out
);

  typedef enum logic [2:0] {IDLE, ARBIT, AREF, WRITE, READ} state_t;

  state_t state;
  logic   pick_wr;

`ifdef SDRAM_ARB_RR_EN
  // rr_flag = 1 means the last write/read grant went to write
  logic rr_flag;
  assign pick_wr = wr_req && !(rd_req && rr_flag);
`else
  assign pick_wr = wr_req;
`endif

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state   <= IDLE;
      aref_en <= 1'b0;
      wr_en   <= 1'b0;
      rd_en   <= 1'b0;
`ifdef SDRAM_ARB_RR_EN
      rr_flag <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (init_end) state <= ARBIT;
        end
        ARBIT: begin
          if (aref_req) begin
            state   <= AREF;
            aref_en <= 1'b1;
          end else if (pick_wr) begin
            state <= WRITE;
            wr_en <= 1'b1;
`ifdef SDRAM_ARB_RR_EN
            rr_flag <= 1'b1;
`endif
          end else if (rd_req) begin
            state <= READ;
            rd_en <= 1'b1;
`ifdef SDRAM_ARB_RR_EN
            rr_flag <= 1'b0;
`endif
          end
        end
        AREF: begin
          if (aref_end) begin
            state   <= ARBIT;
            aref_en <= 1'b0;
          end
        end
        WRITE: begin
          if (wr_end) begin
            state <= ARBIT;
            wr_en <= 1'b0;
          end
        end
        READ: begin
          if (rd_end) begin
            state <= ARBIT;
            rd_en <= 1'b0;
          end
        end
        default: begin
          state   <= IDLE;
          aref_en <= 1'b0;
          wr_en   <= 1'b0;
          rd_en   <= 1'b0;
        end
      endcase
    end
  end

  // Bus ownership follows the state directly, so the mux is purely combinational.
  always_comb begin
    sdram_cmd    = CMD_NOP;
    sdram_ba     = 2'b00;
    sdram_addr   = '0;
    sdram_dq_oe  = 1'b0;
    sdram_dq_out = 16'h0000;
    case (state)
      IDLE: begin
        sdram_cmd  = init_cmd;
        sdram_ba   = init_ba;
        sdram_addr = init_addr;
      end
      AREF: begin
        sdram_cmd  = aref_cmd;
        sdram_ba   = aref_ba;
        sdram_addr = aref_addr;
      end
      WRITE: begin
        sdram_cmd    = wr_cmd;
        sdram_ba     = wr_ba;
        sdram_addr   = wr_addr;
        sdram_dq_oe  = wr_dq_oe;
        sdram_dq_out = wr_data;
      end
      READ: begin
        sdram_cmd  = rd_cmd;
        sdram_ba   = rd_ba;
        sdram_addr = rd_addr;
      end
      default: ;
    endcase
  end

endmodule
